// File: rtl/scmp_microcode_pak.sv
// Shared microcode field definitions for the SC/MP microsequencer and PLA.
// Condition-bit and control-bit indices plus the default microaddress type.
package scmp_microcode_pak;

  localparam int unsigned USEQ_PC_W   = 8;
  localparam int unsigned USEQ_COND_W = 7;
  localparam int unsigned USEQ_NEXT_W = 5;

  typedef logic [USEQ_PC_W-1:0] USEQ_PC_t;

  // Condition inputs as wired from the datapath.
  localparam int unsigned COND_IX_CARRY = 0;
  localparam int unsigned COND_IX_OVF   = 1;
  localparam int unsigned COND_IX_SA    = 2;
  localparam int unsigned COND_IX_SB    = 3;
  localparam int unsigned COND_IX_ACZ   = 4;
  localparam int unsigned COND_IX_ACNEG = 5;
  localparam int unsigned COND_IX_IEN   = 6;

  // Sequencer control bits within the microword control field.
  localparam int unsigned CTL_IX_DECODE = 0;
  localparam int unsigned CTL_IX_CALL   = 1;
  localparam int unsigned CTL_IX_RET    = 2;
  localparam int unsigned CTL_W         = 3;

  typedef enum logic [1:0] {
    StkNone,
    StkPush,
    StkPop,
    StkReplace
  } stk_op_e;

  function automatic stk_op_e stk_op_decode(input logic push, input logic pop);
    unique case ({push, pop})
      2'b10:   return StkPush;
      2'b01:   return StkPop;
      2'b11:   return StkReplace;
      default: return StkNone;
    endcase
  endfunction

endpackage

// File: rtl/scmp_useq_stack.sv
// Microcode return-address LIFO with push, pop and replace-top (tail call).
// SCMP_USEQ_STACK_CHECK_EN: drop pushes when full; otherwise overwrite the oldest entry.
module scmp_useq_stack
  import scmp_microcode_pak::*;
#(
  parameter int unsigned W     = USEQ_PC_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           top,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty,
  output logic                   push_drop,
  output logic                   pop_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d, top_ix, wr_ix;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  stk_op_e       op;

  // ptr_q is the next free slot; when full it also points at the oldest entry.
  assign top_ix = ptr_q - 1'b1;
  assign top    = mem_q[top_ix];
  assign depth  = cnt_q;
  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign op     = stk_op_decode(push, pop);

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_ix     = ptr_q;
    push_drop = 1'b0;
    pop_empty = 1'b0;
    unique case (op)
      StkReplace: begin
        if (empty) begin
          // Nothing to replace: the return misses, the call still pushes.
          pop_empty = 1'b1;
          wr_en     = 1'b1;
          ptr_d     = ptr_q + 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end else begin
          wr_en = 1'b1;
          wr_ix = top_ix;
        end
      end
      StkPush: begin
        if (full) begin
`ifdef SCMP_USEQ_STACK_CHECK_EN
          push_drop = 1'b1;
`else
          wr_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
`endif
        end else begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StkPop: begin
        if (empty) begin
          pop_empty = 1'b1;
        end else begin
          ptr_d = top_ix;
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ix] <= push_data;
    end
  end

endmodule

// File: rtl/scmp_useq.sv
// SC/MP microsequencer: masked condition test, next-microaddress select, return stack.
// SCMP_USEQ_STACK_CHECK_EN enables sticky overflow/underflow flags.
module scmp_useq
  import scmp_microcode_pak::*;
#(
  parameter int unsigned PC_W     = USEQ_PC_W,
  parameter int unsigned NEXT_W   = USEQ_NEXT_W,
  parameter int unsigned COND_W   = USEQ_COND_W,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [PC_W-1:0]        op_pc,
  input  logic [COND_W-1:0]      cond_in,
  input  logic [COND_W-1:0]      cond_mask,
  input  logic [COND_W-1:0]      cond_xor,
  input  logic [NEXT_W-1:0]      nextpc,
  input  logic                   ctl_decode,
  input  logic                   ctl_call,
  input  logic                   ctl_ret,
  output logic [PC_W-1:0]        mc_pc,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   err_ovf,
  output logic                   err_unf
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  logic [PC_W-1:0] mc_pc_q, pc_d, pc_inc, rel_ext, stk_top;
  logic            cond, stk_empty, stk_full, stk_push, stk_pop;
  logic            push_drop, pop_empty;

  assign cond    = |((cond_in ^ cond_xor) & cond_mask);
  assign pc_inc  = mc_pc_q + 1'b1;
  assign rel_ext = PC_W'($signed(nextpc));
  assign mc_pc   = mc_pc_q;

  // A stalled microword must not touch the stack; it replays once unstalled.
  assign stk_push = ctl_call & ~stall;
  assign stk_pop  = ctl_ret & ~stall;

  always_comb begin
    pc_d = mc_pc_q;
    if (!stall) begin
      if (ctl_decode) begin
        pc_d = op_pc;
      end else if (ctl_ret) begin
        pc_d = stk_empty ? RST_PC : stk_top;
      end else if (cond) begin
        pc_d = pc_inc;
      end else if (nextpc == '0) begin
        pc_d = RST_PC;
      end else begin
        pc_d = mc_pc_q + rel_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_pc_q <= RST_PC;
    end else begin
      mc_pc_q <= pc_d;
    end
  end

  scmp_useq_stack #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .depth     (depth),
    .full      (stk_full),
    .empty     (stk_empty),
    .push_drop (push_drop),
    .pop_empty (pop_empty)
  );

`ifdef SCMP_USEQ_STACK_CHECK_EN
  logic err_ovf_q, err_unf_q;
  logic unused_full;
  assign unused_full = stk_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_q | push_drop;
      err_unf_q <= err_unf_q | pop_empty;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
`else
  logic unused_flags;
  assign unused_flags = push_drop ^ pop_empty ^ stk_full;
  assign err_ovf      = 1'b0;
  assign err_unf      = 1'b0;
`endif

endmodule

// File: tb/tb_scmp_useq.sv
// Directed bench for scmp_useq: default DUT plus a DEPTH=2 instance for overflow behaviour.
module tb_scmp_useq;

  logic       clk;
  logic       rst;
  logic       stall;
  logic [7:0] op_pc;
  logic [6:0] cond_in, cond_mask, cond_xor;
  logic [4:0] nextpc;
  logic       ctl_decode, ctl_call, ctl_ret;
  logic [7:0] mc_pc;
  logic [2:0] depth;
  logic       err_ovf, err_unf;

  logic [7:0] op_pc2;
  logic       ctl_decode2, ctl_call2, ctl_ret2;
  logic [7:0] mc_pc2;
  logic [1:0] depth2;
  logic       err_ovf2, err_unf2;

  int total = 0;
  int bad   = 0;

`ifdef SCMP_USEQ_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  scmp_useq u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .op_pc      (op_pc),
    .cond_in    (cond_in),
    .cond_mask  (cond_mask),
    .cond_xor   (cond_xor),
    .nextpc     (nextpc),
    .ctl_decode (ctl_decode),
    .ctl_call   (ctl_call),
    .ctl_ret    (ctl_ret),
    .mc_pc      (mc_pc),
    .depth      (depth),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf)
  );

  scmp_useq #(
    .DEPTH (2)
  ) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .stall      (1'b0),
    .op_pc      (op_pc2),
    .cond_in    (7'd0),
    .cond_mask  (7'd0),
    .cond_xor   (7'd0),
    .nextpc     (5'd0),
    .ctl_decode (ctl_decode2),
    .ctl_call   (ctl_call2),
    .ctl_ret    (ctl_ret2),
    .mc_pc      (mc_pc2),
    .depth      (depth2),
    .err_ovf    (err_ovf2),
    .err_unf    (err_unf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ctl_decode = 0; ctl_call = 0; ctl_ret = 0;
    cond_in = 0; cond_mask = 0; cond_xor = 0; nextpc = 0;
  endtask

  task automatic go(input logic [7:0] pc);
    idle();
    ctl_decode = 1; op_pc = pc;
    step();
    ctl_decode = 0;
  endtask

  initial begin
    rst = 1; stall = 0; op_pc = 0; idle();
    op_pc2 = 0; ctl_decode2 = 0; ctl_call2 = 0; ctl_ret2 = 0;
    step(); step();
    rst = 0;
    chk("rst_pc", 32'(mc_pc), 32'h00);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_ovf", 32'(err_ovf), 0);
    chk("rst_unf", 32'(err_unf), 0);

    go(8'h40);
    chk("decode_40", 32'(mc_pc), 32'h40);

    go(8'h10);
    nextpc = 5'b11101;
    step();
    chk("rel_neg3", 32'(mc_pc), 32'h0D);

    go(8'h10);
    nextpc = 5'd0;
    step();
    chk("next_zero", 32'(mc_pc), 32'h00);

    go(8'hFF);
    cond_in = 7'b0000001; cond_mask = 7'b0000001;
    step();
    chk("cond_wrap", 32'(mc_pc), 32'h00);

    // Inverted polarity makes cond false, so the relative field is used.
    cond_in = 7'b0010000; cond_xor = 7'b0010000; cond_mask = 7'b0010000; nextpc = 5'd1;
    step();
    chk("cond_xor_false", 32'(mc_pc), 32'h01);
    cond_mask = 0; nextpc = 5'b11101;
    step();
    chk("rel_wrap_down", 32'(mc_pc), 32'hFE);

    go(8'h20);
    ctl_call = 1; ctl_decode = 1; op_pc = 8'h30; step();
    op_pc = 8'h40; step();
    op_pc = 8'h60; step();
    idle();
    chk("call3_pc", 32'(mc_pc), 32'h60);
    chk("call3_depth", 32'(depth), 3);

    ctl_ret = 1; step();
    chk("ret1_pc", 32'(mc_pc), 32'h41);
    step();
    chk("ret2_pc", 32'(mc_pc), 32'h31);
    chk("ret2_depth", 32'(depth), 1);

    go(8'h50);
    ctl_call = 1; ctl_ret = 1; step();
    idle();
    chk("tail_pc", 32'(mc_pc), 32'h21);
    chk("tail_depth", 32'(depth), 1);
    ctl_ret = 1; step();
    chk("tail_newtop", 32'(mc_pc), 32'h51);
    chk("tail_depth0", 32'(depth), 0);
    step();
    chk("ret_empty_pc", 32'(mc_pc), 32'h00);
    chk("ret_empty_depth", 32'(depth), 0);
    chk("ret_empty_unf", 32'(err_unf), 32'(CHK));
    chk("ret_empty_ovf", 32'(err_ovf), 0);

    go(8'h70);
    stall = 1; ctl_call = 1; ctl_decode = 1; op_pc = 8'h90;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(mc_pc), 32'h70);
      chk("stall_depth", 32'(depth), 0);
    end
    stall = 0; step();
    idle();
    chk("unstall_pc", 32'(mc_pc), 32'h90);
    chk("unstall_depth", 32'(depth), 1);
    ctl_ret = 1; step();
    idle();
    chk("unstall_ret", 32'(mc_pc), 32'h71);

    go(8'h33);
    ctl_call = 1; step();
    idle();
    chk("pre_rst_depth", 32'(depth), 1);
    rst = 1; stall = 1; step();
    rst = 0; stall = 0;
    chk("rst_stall_pc", 32'(mc_pc), 32'h00);
    chk("rst_stall_depth", 32'(depth), 0);
    chk("rst_clr_unf", 32'(err_unf), 0);

    // DEPTH=2 instance: three calls, third overflows.
    ctl_call2 = 1; ctl_decode2 = 1;
    op_pc2 = 8'h10; step();
    op_pc2 = 8'h20; step();
    op_pc2 = 8'h30; step();
    ctl_call2 = 0; ctl_decode2 = 0;
    chk("d2_pc", 32'(mc_pc2), 32'h30);
    chk("d2_depth", 32'(depth2), 2);
    chk("d2_ovf", 32'(err_ovf2), 32'(CHK));
    ctl_ret2 = 1; step();
    chk("d2_ret1", 32'(mc_pc2), CHK ? 32'h11 : 32'h21);
    step();
    chk("d2_ret2", 32'(mc_pc2), CHK ? 32'h01 : 32'h11);
    step();
    chk("d2_ret3", 32'(mc_pc2), 32'h00);
    chk("d2_depth0", 32'(depth2), 0);
    chk("d2_unf", 32'(err_unf2), 32'(CHK));
    ctl_ret2 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
